accel_sum_collector: RTL and testbench

//   Downstream stage for dummy_accel. Takes the 9-bit sum stream over a valid/ready port.

---
 rtl/accel_sum_collector_if.sv | 23 ++
 rtl/accel_sum_collector.sv | 105 ++++++++++
 tb/tb_accel_sum_collector.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/accel_sum_collector_if.sv
// Stream bundle for accel_sum_collector: sum input port and batch-total output port.
// master = upstream producer / downstream consumer side, slave = the collector.
interface accel_sum_collector_if #(
  parameter int unsigned SUM_W = 9,
  parameter int unsigned ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/accel_sum_collector.sv
// Sums every BATCH accepted beats into one total and queues totals in a FWFT FIFO.
// Optional ACCEL_COLLECTOR_SAT_EN: each add saturates instead of wrapping modulo 2^ACC_W.
module accel_sum_collector #(
  parameter int unsigned SUM_W = 9,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned BATCH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  accel_sum_collector_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [$clog2(BATCH+1)-1:0]   beat_cnt,
  output logic                         acc_ovf
);

  localparam int unsigned CNT_W = $clog2(BATCH + 1);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned EXT_W = ACC_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BATCH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

  logic [SUM_W-1:0] sum_in;
  logic [ACC_W-1:0] acc;
  logic [EXT_W-1:0] add_ext;
  logic [ACC_W-1:0] add_res;
  logic             add_carry;
  logic             in_fire;
  logic             out_fire;
  logic             last_beat;
  logic             push;

  logic [ACC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: space check uses only registered level, so a same-cycle pop frees nothing
  assign sum_in        = bus.in_sum;
  assign bus.in_ready  = rst_n & (fifo_level < FULL_LVL);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (fifo_level != '0);
  assign out_fire      = bus.out_valid & bus.out_ready;
  assign last_beat     = (beat_cnt == LAST_BEAT);
  assign push          = in_fire & last_beat;
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  // One extra bit catches the carry out of the accumulator
  always_comb begin
    add_ext   = {1'b0, acc} + EXT_W'(sum_in);
    add_carry = add_ext[ACC_W];
`ifdef ACCEL_COLLECTOR_SAT_EN
    add_res   = add_carry ? '1 : add_ext[ACC_W-1:0];
`else
    add_res   = add_ext[ACC_W-1:0];
`endif
  end

  // Batch accumulator; the last beat of a batch goes to the FIFO and restarts from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      acc_ovf  <= 1'b0;
    end else if (in_fire) begin
      if (add_carry) acc_ovf <= 1'b1;
      if (last_beat) begin
        acc      <= '0;
        beat_cnt <= '0;
      end else begin
        acc      <= add_res;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (out_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, out_fire})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while fifo_level covers them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= add_res;
  end

endmodule

// File: tb/tb_accel_sum_collector.sv
// Bench for accel_sum_collector: directed beats, expected totals queued and checked by monitors.
module tb_accel_sum_collector;

  logic clk;
  logic rst_n;

  accel_sum_collector_if #(.SUM_W(9), .ACC_W(16)) bus ();
  accel_sum_collector_if #(.SUM_W(9), .ACC_W(10)) bus10 ();

  logic [2:0] fifo_level, fifo_level10;
  logic [2:0] beat_cnt, beat_cnt10;
  logic       acc_ovf, acc_ovf10;

  accel_sum_collector #(.SUM_W(9), .ACC_W(16), .BATCH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_level (fifo_level),
    .beat_cnt   (beat_cnt),
    .acc_ovf    (acc_ovf)
  );

  accel_sum_collector #(.SUM_W(9), .ACC_W(10), .BATCH(4), .DEPTH(4)) dut10 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus10),
    .fifo_level (fifo_level10),
    .beat_cnt   (beat_cnt10),
    .acc_ovf    (acc_ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  longint exp_q[$];
  longint exp10_q[$];

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic send(input logic [8:0] v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = v;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send10(input logic [8:0] v);
    int n = 0;
    bus10.in_valid = 1'b1;
    bus10.in_sum   = v;
    @(negedge clk);
    while (!bus10.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus10.in_ready) chk("send10_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus10.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid || exp10_q.size() != 0 || bus10.out_valid)
           && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  int peak;

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_sum      = '0;
    bus.out_ready   = 1'b0;
    bus10.in_valid  = 1'b0;
    bus10.in_sum    = '0;
    bus10.out_ready = 1'b1;

    // Scoreboard monitors: compare the head whenever a pop happens on the next edge
    fork
      forever begin
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_pop", longint'(bus.out_data), -1);
          else chk("out_data", longint'(bus.out_data), exp_q.pop_front());
        end
      end
      forever begin
        @(negedge clk);
        if (bus10.out_valid && bus10.out_ready) begin
          if (exp10_q.size() == 0) chk("unexpected_pop10", longint'(bus10.out_data), -1);
          else chk("out_data10", longint'(bus10.out_data), exp10_q.pop_front());
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_level", longint'(fifo_level), 0);
    chk("rst_beat_cnt", longint'(beat_cnt), 0);
    chk("rst_acc_ovf", longint'(acc_ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: one batch, total visible the cycle after the 4th beat
    bus.out_ready = 1'b1;
    exp_q.push_back(122);
    send(10);  chk("t1_beat1", longint'(beat_cnt), 1);
    send(5);   chk("t1_beat2", longint'(beat_cnt), 2);
    send(100); chk("t1_beat3", longint'(beat_cnt), 3);
    chk("t1_not_yet_valid", longint'(bus.out_valid), 0);
    send(7);   chk("t1_beat0", longint'(beat_cnt), 0);
    chk("t1_valid", longint'(bus.out_valid), 1);
    chk("t1_head", longint'(bus.out_data), 122);
    chk("t1_level", longint'(fifo_level), 1);
    wait_drain();
    chk("t1_ovf", longint'(acc_ovf), 0);

    // 2: two batches of 255s drained as they appear
    exp_q.push_back(1020);
    exp_q.push_back(1020);
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      send(255);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    wait_drain();
    chk("t2_peak_level", longint'(peak), 1);
    chk("t2_ovf", longint'(acc_ovf), 0);

    // 3: fill the FIFO, verify stall, then pop-only at full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(1);
    chk("t3_full_level", longint'(fifo_level), 4);
    chk("t3_full_in_ready", longint'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_sum   = 9'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_stall_beat_cnt", longint'(beat_cnt), 0);
    chk("t3_stall_level", longint'(fifo_level), 4);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(4);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_pop_level", longint'(fifo_level), 3);
    chk("t3_pop_in_ready", longint'(bus.in_ready), 1);
    wait_drain();

    // 4: push the closing beat and pop in the same cycle at level 2
    bus.out_ready = 1'b0;
    exp_q.push_back(10);
    exp_q.push_back(26);
    exp_q.push_back(40);
    send(1); send(2); send(3); send(4);
    send(5); send(6); send(7); send(8);
    send(10); send(10); send(10);
    chk("t4_level_before", longint'(fifo_level), 2);
    bus.in_valid  = 1'b1;
    bus.in_sum    = 9'd10;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t4_level_after", longint'(fifo_level), 2);
    chk("t4_beat_cnt", longint'(beat_cnt), 0);
    wait_drain();

    // 5: narrow accumulator overflow (wrap or clamp)
`ifdef ACCEL_COLLECTOR_SAT_EN
    exp10_q.push_back(1023);
`else
    exp10_q.push_back(1020);
`endif
    for (int i = 0; i < 4; i++) send10(511);
    chk("t5_ovf", longint'(acc_ovf10), 1);
    wait_drain();

    // 6: reset mid-batch with a queued entry discards both
    bus.out_ready = 1'b0;
    send(1); send(1); send(1); send(1);
    send(10); send(20);
    chk("t6_pre_level", longint'(fifo_level), 1);
    chk("t6_pre_beat_cnt", longint'(beat_cnt), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_in_ready", longint'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("t6_rst_beat_cnt", longint'(beat_cnt), 0);
    chk("t6_rst_level", longint'(fifo_level), 0);
    chk("t6_rst_out_valid", longint'(bus.out_valid), 0);
    chk("t6_rst_ovf10", longint'(acc_ovf10), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(10);
    send(1); send(2); send(3); send(4);
    chk("t6_head", longint'(bus.out_data), 10);
    wait_drain();
    chk("t6_q_empty", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
